// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: sequencer states, grant ids
// and the requester count that sizes the per-requester vectors.
package mem_arbiter_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic {
        IDLE,
        ACCESS
    } arb_state_t;

    // Values double as indices into the per-requester vectors.
    typedef enum logic [1:0] {
        GRANT_DATA  = 2'd0,
        GRANT_FETCH = 2'd1,
        GRANT_DEBUG = 2'd2
    } arb_grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; master is the datapath/memory side that drives it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              f_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;
    logic              mem_ready;

    logic              stall;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, dbg_req, dbg_addr,
               mem_rd, mem_ready,
        output f_rdata, f_ack, d_rdata, d_ack, dbg_rdata, dbg_ack,
               mem_req, mem_we, mem_addr, mem_wd, stall
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, dbg_req, dbg_addr,
               mem_rd, mem_ready,
        input  f_rdata, f_ack, d_rdata, d_ack, dbg_rdata, dbg_ack,
               mem_req, mem_we, mem_addr, mem_wd, stall
    );
endinterface

// File: rtl/mem_arbiter_arb_priority.sv
// Combinational grant picker: data > fetch > debug, except a starved debug
// request jumps the queue.
module arb_priority
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig,
    input  logic               starve,
    output arb_grant_t         grant,
    output logic               valid
);

    always_comb begin
        valid = |elig;
        grant = GRANT_DATA;
        if (starve && elig[GRANT_DEBUG])
            grant = GRANT_DEBUG;
        else if (elig[GRANT_DATA])
            grant = GRANT_DATA;
        else if (elig[GRANT_FETCH])
            grant = GRANT_FETCH;
        else if (elig[GRANT_DEBUG])
            grant = GRANT_DEBUG;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch, data and debug accesses onto one memory port with an
// IDLE/ACCESS sequencer, registered read data and one-cycle acks.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic   clock,
    input  logic   reset,
    mem_arbiter_if.slave bus
);

    localparam int             CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  STARVE_TOP = CW'(STARVE_MAX);

    arb_state_t                       state_q, state_d;
    arb_grant_t                       grant_q, grant_d;
    logic                             mem_req_q, mem_req_d;
    logic                             mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]                mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]                mem_wd_q, mem_wd_d;
    logic [NUM_REQ-1:0]               ack_q, ack_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]                    starve_q, starve_d;

    logic [NUM_REQ-1:0] req, elig;
    arb_grant_t         pick;
    logic               pick_vld;

    assign req  = {bus.dbg_req, bus.f_req, bus.d_req};
    // A requester whose ack is out this cycle is still holding req high.
    assign elig = req & ~ack_q;

    arb_priority u_prio (
        .elig   (elig),
        .starve (starve_q == STARVE_TOP),
        .grant  (pick),
        .valid  (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        starve_d   = starve_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d   = ACCESS;
                    grant_d   = pick;
                    mem_req_d = 1'b1;
                    mem_we_d  = (pick == GRANT_DATA) && bus.d_we;
                    mem_wd_d  = (pick == GRANT_DATA) ? bus.d_wdata : '0;
                    case (pick)
                        GRANT_DATA:  mem_addr_d = bus.d_addr;
                        GRANT_FETCH: mem_addr_d = bus.f_addr;
                        default:     mem_addr_d = bus.dbg_addr;
                    endcase
                    if (pick == GRANT_DEBUG)
                        starve_d = '0;
                    else if (bus.dbg_req && starve_q != STARVE_TOP)
                        starve_d = starve_q + CW'(1);
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    state_d          = IDLE;
                    mem_req_d        = 1'b0;
                    mem_we_d         = 1'b0;
                    rdata_d[grant_q] = bus.mem_rd;
                    ack_d[grant_q]   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_DATA;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wd    = mem_wd_q;
    assign bus.d_ack     = ack_q[GRANT_DATA];
    assign bus.f_ack     = ack_q[GRANT_FETCH];
    assign bus.dbg_ack   = ack_q[GRANT_DEBUG];
    assign bus.d_rdata   = rdata_q[GRANT_DATA];
    assign bus.f_rdata   = rdata_q[GRANT_FETCH];
    assign bus.dbg_rdata = rdata_q[GRANT_DEBUG];
    assign bus.stall     = (bus.f_req & ~bus.f_ack) | (bus.d_req & ~bus.d_ack);

endmodule
